// File: rtl/timekeeper_ctrl.sv
// Restart sequencer and event counter for the timekeeper tick generator.
// Turns each sticky tick into one counted event, with compare/irq and a word-addressed register port.
module timekeeper_ctrl #(
   parameter int          CountBits    = 32,
   parameter logic [31:0] CompareReset = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        res,
   input  logic        tk_tick,
   output logic        tk_res,
   input  logic        sel,
   input  logic        we,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ack,
   output logic        irq
);

   // state   | meaning
   // IDLE    | disabled, timekeeper held in reset
   // RESTART | one-cycle timekeeper reset, stale tick ignored
   // WAIT    | timekeeper running, waiting for tick
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RESTART = 2'd1,
      ST_WAIT    = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [CountBits-1:0] count_q;
   logic [CountBits-1:0] compare_q;
   logic [2:0]           ctrl_q;
   logic                 pending_q;
   logic                 overflow_q;
   logic                 inc;

   logic en, autoreload, irq_en;
   assign en         = ctrl_q[0];
   assign autoreload = ctrl_q[1];
   assign irq_en     = ctrl_q[2];

   always_ff @(posedge clk or negedge res) begin
      if (!res) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      tk_res  = 1'b1;
      inc     = 1'b0;
      case (state_q)
         ST_IDLE:    if (en) state_d = ST_RESTART;
         ST_RESTART: state_d = ST_WAIT;
         ST_WAIT: begin
            tk_res = 1'b0;
            if (tk_tick) begin
               inc     = 1'b1;
               state_d = ST_RESTART;
            end
         end
         default:    state_d = ST_IDLE;
      endcase
      // Disabling overrides everything, including a tick arriving this cycle.
      if (!en) begin
         state_d = ST_IDLE;
         inc     = 1'b0;
      end
   end

   logic wr_count, wr_compare, wr_ctrl, wr_status;
   assign wr_count   = sel && we && (addr == 2'd0);
   assign wr_compare = sel && we && (addr == 2'd1);
   assign wr_ctrl    = sel && we && (addr == 2'd2);
   assign wr_status  = sel && we && (addr == 2'd3);

   logic [CountBits-1:0] count_next;
   logic                 hit, ovf_set;
   assign count_next = count_q + CountBits'(1);
   assign hit        = inc && (count_next == compare_q);
   assign ovf_set    = inc && (&count_q);

   logic [31:0] rd_mux;
   always_comb begin
      rd_mux = 32'd0;
      case (addr)
         2'd0: rd_mux = 32'(count_q);
         2'd1: rd_mux = 32'(compare_q);
         2'd2: rd_mux = {29'd0, ctrl_q};
         2'd3: rd_mux = {30'd0, overflow_q, pending_q};
         default: rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         count_q    <= '0;
         compare_q  <= CompareReset[CountBits-1:0];
         ctrl_q     <= 3'd0;
         pending_q  <= 1'b0;
         overflow_q <= 1'b0;
         irq        <= 1'b0;
         rdata      <= 32'd0;
         ack        <= 1'b0;
      end else begin
         if (wr_count)
            count_q <= wdata[CountBits-1:0];
         else if (inc)
            count_q <= (hit && autoreload) ? '0 : count_next;
         if (wr_compare) compare_q <= wdata[CountBits-1:0];
         if (wr_ctrl)    ctrl_q    <= wdata[2:0];
         // Hardware set beats a simultaneous write-1-to-clear.
         pending_q  <= hit     | (pending_q  & ~(wr_status & wdata[0]));
         overflow_q <= ovf_set | (overflow_q & ~(wr_status & wdata[1]));
         irq        <= pending_q & irq_en;
         ack        <= sel;
         if (sel) rdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_timekeeper_ctrl.sv
// Scoreboarded bench for timekeeper_ctrl with a behavioural timekeeper (Wait=2) driving tk_tick.
module tb_timekeeper_ctrl;

   localparam int WAIT_CYC = 2;

   logic        clk = 1'b0;
   logic        res = 1'b0;
   logic        tk_tick = 1'b0;
   logic        tk_res;
   logic        sel = 1'b0;
   logic        we = 1'b0;
   logic [1:0]  addr = 2'd0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic        ack;
   logic        irq;
   int          tk_cnt = 0;

   timekeeper_ctrl dut (
      .clk(clk), .res(res), .tk_tick(tk_tick), .tk_res(tk_res),
      .sel(sel), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ack(ack), .irq(irq)
   );

   always #5 clk = ~clk;

   // Timekeeper model: sync reset, counts Wait cycles, then holds a sticky tick.
   always @(posedge clk) begin
      if (tk_res) begin
         tk_cnt  <= 0;
         tk_tick <= 1'b0;
      end else if (tk_cnt == WAIT_CYC - 1) begin
         tk_tick <= 1'b1;
      end else begin
         tk_cnt <= tk_cnt + 1;
      end
   end

   typedef struct {
      bit          chk;
      logic [31:0] exp;
      logic [1:0]  a;
      int          id;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   vectors = 0;
   int   miscompares = 0;
   int   acc_id = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // Called at a negedge; the access is sampled at the next posedge, returns at the following negedge.
   task automatic access(input bit w, input logic [1:0] a, input logic [31:0] d,
                         input bit chk, input logic [31:0] exp);
      exp_t e;
      e.chk = chk;
      e.exp = exp;
      e.a   = a;
      e.id  = acc_id;
      acc_id++;
      sbq.push_back(e);
      sel = 1'b1; we = w; addr = a; wdata = d;
      @(negedge clk);
      sel = 1'b0; we = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic setup(input logic [31:0] cmp, input logic [31:0] cnt);
      access(1'b1, 2'd2, 32'd0, 1'b0, 32'd0);
      access(1'b1, 2'd0, cnt,   1'b0, 32'd0);
      access(1'b1, 2'd3, 32'd3, 1'b0, 32'd0);
      access(1'b1, 2'd1, cmp,   1'b0, 32'd0);
   endtask

   always @(negedge clk) begin
      if (ack) begin
         if (sbq.size() == 0) begin
            check_bit("ack_unexpected", ack, 1'b0);
         end else begin
            mon_e = sbq.pop_front();
            if (mon_e.chk)
               check($sformatf("rd%0d_addr%0d", mon_e.id, mon_e.a), rdata, mon_e.exp);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      // Reset and idle
      #2;
      check_bit("rst_tk_res", tk_res, 1'b1);
      check_bit("rst_irq", irq, 1'b0);
      check_bit("rst_ack", ack, 1'b0);
      check("rst_rdata", rdata, 32'd0);
      repeat (2) @(negedge clk);
      res = 1'b1;
      for (int i = 0; i < 20; i++) begin
         check_bit("idle_tk_res", tk_res, 1'b1);
         check_bit("idle_irq", irq, 1'b0);
         @(negedge clk);
      end
      access(1'b0, 2'd0, 32'd0, 1'b1, 32'd0);
      access(1'b0, 2'd1, 32'd0, 1'b1, 32'hFFFF_FFFF);
      access(1'b0, 2'd2, 32'd0, 1'b1, 32'd0);
      access(1'b0, 2'd3, 32'd0, 1'b1, 32'd0);

      // Basic counting: increments land 5, 9, 13 cycles after the CTRL write edge.
      setup(32'hFFFF_FFFF, 32'd0);
      access(1'b1, 2'd2, 32'd1, 1'b0, 32'd0);
      fork
         begin
            idle(6);
            access(1'b0, 2'd0, 32'd0, 1'b1, 32'd1);
            idle(3);
            access(1'b0, 2'd0, 32'd0, 1'b1, 32'd2);
            idle(3);
            access(1'b0, 2'd0, 32'd0, 1'b1, 32'd3);
         end
         begin
            for (int k = 1; k <= 16; k++) begin
               check_bit("tk_res_period", tk_res, (k == 1) || ((k - 2) % 4 == 0));
               @(negedge clk);
            end
         end
      join

      // Compare with autoreload and irq
      setup(32'd3, 32'd0);
      access(1'b1, 2'd2, 32'd7, 1'b0, 32'd0);
      idle(13);
      check_bit("irq_before", irq, 1'b0);
      idle(1);
      check_bit("irq_set", irq, 1'b1);
      access(1'b0, 2'd3, 32'd0, 1'b1, 32'd1);
      access(1'b0, 2'd0, 32'd0, 1'b1, 32'd0);
      access(1'b1, 2'd3, 32'd1, 1'b1, 32'd1);
      idle(1);
      check_bit("irq_cleared", irq, 1'b0);
      access(1'b0, 2'd0, 32'd0, 1'b1, 32'd1);
      idle(3);
      access(1'b0, 2'd0, 32'd0, 1'b1, 32'd2);

      // Compare without autoreload
      setup(32'd2, 32'd0);
      access(1'b1, 2'd2, 32'd1, 1'b0, 32'd0);
      idle(10);
      access(1'b0, 2'd3, 32'd0, 1'b1, 32'd1);
      idle(3);
      access(1'b0, 2'd0, 32'd0, 1'b1, 32'd3);
      check_bit("irq_masked", irq, 1'b0);

      // Overflow on wrap
      setup(32'd5, 32'hFFFF_FFFF);
      access(1'b1, 2'd2, 32'd1, 1'b0, 32'd0);
      idle(6);
      access(1'b0, 2'd3, 32'd0, 1'b1, 32'd2);
      access(1'b0, 2'd0, 32'd0, 1'b1, 32'd0);

      // W1C colliding with compare hit, then COUNT write colliding with increment
      setup(32'd1, 32'd0);
      access(1'b1, 2'd2, 32'd1, 1'b0, 32'd0);
      idle(4);
      access(1'b1, 2'd3, 32'd1, 1'b1, 32'd0);
      access(1'b0, 2'd3, 32'd0, 1'b1, 32'd1);
      idle(2);
      access(1'b1, 2'd0, 32'h10, 1'b1, 32'd1);
      access(1'b0, 2'd0, 32'd0, 1'b1, 32'h10);
      idle(3);
      access(1'b0, 2'd0, 32'd0, 1'b1, 32'h11);

      // Disable on the same edge the tick rises
      setup(32'hFFFF_FFFF, 32'd0);
      access(1'b1, 2'd2, 32'd1, 1'b0, 32'd0);
      idle(3);
      access(1'b1, 2'd2, 32'd0, 1'b1, 32'd1);
      check_bit("dis_tk_res_wait", tk_res, 1'b0);
      idle(1);
      check_bit("dis_tk_res_idle", tk_res, 1'b1);
      access(1'b0, 2'd0, 32'd0, 1'b1, 32'd0);
      idle(4);
      access(1'b0, 2'd0, 32'd0, 1'b1, 32'd0);
      access(1'b0, 2'd3, 32'd0, 1'b1, 32'd0);

      // Asynchronous reset mid-WAIT
      setup(32'd1, 32'd0);
      access(1'b1, 2'd2, 32'd7, 1'b0, 32'd0);
      idle(7);
      check_bit("pre_rst_irq", irq, 1'b1);
      check_bit("pre_rst_tk_res", tk_res, 1'b0);
      access(1'b0, 2'd2, 32'd0, 1'b1, 32'd7);
      #1 res = 1'b0;
      #1;
      check_bit("async_tk_res", tk_res, 1'b1);
      check_bit("async_irq", irq, 1'b0);
      check_bit("async_ack", ack, 1'b0);
      check("async_rdata", rdata, 32'd0);
      @(negedge clk);
      res = 1'b1;
      access(1'b0, 2'd0, 32'd0, 1'b1, 32'd0);
      access(1'b0, 2'd1, 32'd0, 1'b1, 32'hFFFF_FFFF);
      access(1'b0, 2'd2, 32'd0, 1'b1, 32'd0);
      access(1'b0, 2'd3, 32'd0, 1'b1, 32'd0);

      idle(2);
      check("sb_empty", 32'(sbq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/timekeeper_ctrl.md
Name: timekeeper_ctrl

Overview:
- Downstream consumer of the `timekeeper` tick generator, and the owner of its restart.
- Converts the sticky `tick` into counted events: holds `timekeeper` in reset, releases it, waits for `tick`, counts one event, then re-arms it.
- Exposes a 32-bit event counter, a compare register and an interrupt to the core through a small word-addressed register port.

Parameters:
- CountBits, 32: width of COUNT and COMPARE (1..32).
- CompareReset, 32'hFFFF_FFFF: reset value of COMPARE.

Ports:
- clk  in  1  system clock.
- res  in  1  reset, asynchronous, active-low (0 = reset).
- tk_tick  in  1  sticky tick from `timekeeper`; stays 1 until `timekeeper` is reset.
- tk_res  out  1  active-high synchronous reset driven into `timekeeper`.
- sel  in  1  register access strobe, one cycle per access.
- we  in  1  1 = write, 0 = read; qualified by `sel`.
- addr  in  2  word address: 0 COUNT, 1 COMPARE, 2 CTRL, 3 STATUS.
- wdata  in  32  write data.
- rdata  out  32  read data, registered.
- ack  out  1  access acknowledge, one-cycle pulse.
- irq  out  1  interrupt request, level.

Behaviour:
- Reset (`res`=0, async):
  - COUNT=0, COMPARE=CompareReset, CTRL=0, STATUS=0.
  - `tk_res`=1, `irq`=0, `rdata`=0, `ack`=0, FSM=IDLE.
- CTRL bits:
  - [0] en.
  - [1] autoreload.
  - [2] irq_en.
  - Other bits read 0.
- STATUS bits:
  - [0] pending.
  - [1] overflow.
  - Both are write-1-to-clear; writing 0 has no effect.
- FSM:
  - IDLE: `tk_res`=1. Go to RESTART when en=1.
  - RESTART: `tk_res`=1 for exactly one cycle. `tk_tick` is ignored here because it may still be stale-high. Go to WAIT.
  - WAIT: `tk_res`=0. When `tk_tick`=1, issue one increment event and go to RESTART.
  - en=0 in any state: next state IDLE. A tick seen in the same cycle that en is cleared is discarded.
- One increment per `timekeeper` period. Period = Wait + 2 clocks: 1 cycle RESTART, 1 cycle of detection latency, Wait cycles of `timekeeper` counting.
- Increment arithmetic (modulo 2^CountBits):
  - next = COUNT+1.
  - If next == COMPARE: set pending. If autoreload=1, COUNT←0; otherwise COUNT←next.
  - Otherwise: COUNT←next.
  - If COUNT was all-ones, next wraps to 0 and overflow is set.
- Register port:
  - Access occurs when `sel`=1.
  - Writes take effect at that clock edge.
  - `ack` and `rdata` are valid on the following cycle (latency 1).
  - `rdata` returns the pre-write register value on a write access.
- Simultaneous events:
  - COUNT write and increment in the same cycle: the write wins, the increment is lost.
  - W1C on pending/overflow and a hardware set in the same cycle: the set wins, so the bit stays 1.
  - COMPARE write and increment in the same cycle: the compare uses the old COMPARE.
- `irq` is registered: `irq` = pending & irq_en, one cycle after either input changes.
- Asserting reset mid-WAIT returns to IDLE immediately; `tk_res` goes to 1 asynchronously.

Test Plan:
- Reset and idle: release reset and hold en=0 for 20 cycles -> `tk_res`=1 throughout, COUNT=0, COMPARE reads 0xFFFF_FFFF, `irq`=0.
- Basic counting: `timekeeper` Wait=2 connected, write CTRL=1 -> COUNT reads 1, 2, 3 at a 4-cycle period; `tk_res` high exactly 1 cycle per period; stale tick in RESTART causes no double count.
- Compare with autoreload: COMPARE=3, CTRL=7 -> after 3 ticks pending=1, COUNT=0, `irq`=1 one cycle later; W1C STATUS=1 -> `irq`=0 next cycle, counting continues 1, 2, 3.
- Compare without autoreload: COMPARE=2, CTRL=1 -> pending set at COUNT=2; COUNT continues to 3; `irq` stays 0 (irq_en=0).
- Overflow and collisions:
  - COUNT=0xFFFF_FFFF, then a tick -> COUNT=0, overflow=1.
  - W1C of pending in the same cycle as a compare hit -> pending remains 1.
  - COUNT write of 0x10 in the same cycle as a tick -> COUNT=0x10.
- Disable and reset mid-operation:
  - Clear en while in WAIT with `tk_tick` rising that cycle -> no increment, FSM=IDLE, `tk_res`=1.
  - Assert `res` asynchronously mid-period -> all registers return to their reset values before the next clock edge.
